// File: rtl/propagation_time_meter.sv
// propagation_time_meter
//   Measures, in i_Clk ticks, the time from a launched pulse (i_Start rising)
//   to its returned echo (i_Echo rising, asynchronous, synchronised here).
//   The result is held on o_Valid/o_Delay/o_Timeout until the consumer acks.
//
//   Optional feature: define PULSE_WIDTH_MEASURE_EN to add o_Width, the
//   number of cycles the synchronised echo stays high after its rising edge.
//   With the macro undefined the meter reports delay only.
//
//   Delay includes the SYNC_STAGES cycles of synchroniser latency; it is not
//   compensated, so a loopback (i_Echo tied to i_Start) reads SYNC_STAGES.
//   SYNC_STAGES must be at least 2.

module propagation_time_meter #(
    parameter int COUNTER_WIDTH = 38,
    parameter int TIMEOUT_TICKS = 1000000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Enable,
    input  logic                     i_Start,
    input  logic                     i_Echo,
    input  logic                     i_Ack,
    output logic                     o_Busy,
    output logic                     o_Valid,
    output logic                     o_Timeout,
    output logic [COUNTER_WIDTH-1:0] o_Delay
`ifdef PULSE_WIDTH_MEASURE_EN
    ,
    output logic [COUNTER_WIDTH-1:0] o_Width
`endif
);

    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_CNT = COUNTER_WIDTH'(TIMEOUT_TICKS);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE     = COUNTER_WIDTH'(1);

`ifdef PULSE_WIDTH_MEASURE_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_COUNT = 3'd2,
        S_WIDTH = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_COUNT = 3'd2,
        S_DONE  = 3'd4
    } state_t;
`endif

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [COUNTER_WIDTH-1:0] delay_q, delay_d;
    logic                     valid_q, valid_d;
    logic                     timeout_q, timeout_d;
`ifdef PULSE_WIDTH_MEASURE_EN
    logic [COUNTER_WIDTH-1:0] width_q, width_d;
`endif

    // Echo synchroniser and edge-detect history.
    logic [SYNC_STAGES-1:0]   echo_sync_q, echo_sync_d;
    logic                     echo_prev_q, echo_prev_d;
    logic                     start_prev_q, start_prev_d;

    logic                     echo_sync;
    logic                     echo_edge;
    logic                     start_edge;
    logic [COUNTER_WIDTH-1:0] count_inc;

    assign echo_sync  = echo_sync_q[SYNC_STAGES-1];
    assign echo_edge  = echo_sync & ~echo_prev_q;
    assign start_edge = i_Start & ~start_prev_q;
    assign count_inc  = count_q + CNT_ONE;

    // Shift the async echo through the synchroniser; remember last start/echo levels.
    always_comb begin
        echo_sync_d  = {echo_sync_q[SYNC_STAGES-2:0], i_Echo};
        echo_prev_d  = echo_sync;
        start_prev_d = i_Start;
    end

    // Next-state and result logic for the measurement FSM.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        count_d   = count_q;
        delay_d   = delay_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
`ifdef PULSE_WIDTH_MEASURE_EN
        width_d   = width_q;
`endif

        if (!i_Enable) begin
            state_d   = S_IDLE;
            count_d   = '0;
            delay_d   = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
`ifdef PULSE_WIDTH_MEASURE_EN
            width_d   = '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                end

                // Wait for the launch; echo edges here belong to no measurement.
                S_ARMED: begin
                    if (start_edge) begin
                        state_d = S_COUNT;
                        count_d = '0;
                    end
                end

                // count_inc equals the cycles elapsed since the start-edge cycle,
                // so it is the delay if the echo edge is seen this cycle.
                S_COUNT: begin
                    count_d = count_inc;
                    if (echo_edge) begin
                        delay_d = count_inc;
`ifdef PULSE_WIDTH_MEASURE_EN
                        // The edge cycle is the first high cycle of the echo.
                        state_d = S_WIDTH;
                        count_d = CNT_ONE;
`else
                        state_d   = S_DONE;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
`endif
                    end else if (count_inc >= TIMEOUT_CNT) begin
                        state_d   = S_DONE;
                        valid_d   = 1'b1;
                        timeout_d = 1'b1;
                        delay_d   = TIMEOUT_CNT;
`ifdef PULSE_WIDTH_MEASURE_EN
                        width_d   = '0;
`endif
                    end
                end

`ifdef PULSE_WIDTH_MEASURE_EN
                // count_q holds the high cycles seen so far; the falling edge closes it.
                S_WIDTH: begin
                    if (!echo_sync && echo_prev_q) begin
                        state_d   = S_DONE;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        width_d   = count_q;
                    end else begin
                        count_d = count_inc;
                        if (count_inc >= TIMEOUT_CNT) begin
                            state_d   = S_DONE;
                            valid_d   = 1'b1;
                            timeout_d = 1'b1;
                            width_d   = TIMEOUT_CNT;
                        end
                    end
                end
`endif

                // Result is frozen until acknowledged; start/echo edges are ignored.
                S_DONE: begin
                    if (i_Ack) begin
                        state_d = S_ARMED;
                        valid_d = 1'b0;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters, results and edge history register with synchronous reset.
    always_ff @(posedge i_Clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_Rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            delay_q      <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            echo_sync_q  <= '0;
            echo_prev_q  <= 1'b0;
            start_prev_q <= 1'b0;
`ifdef PULSE_WIDTH_MEASURE_EN
            width_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            delay_q      <= delay_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            echo_sync_q  <= echo_sync_d;
            echo_prev_q  <= echo_prev_d;
            start_prev_q <= start_prev_d;
`ifdef PULSE_WIDTH_MEASURE_EN
            width_q      <= width_d;
`endif
        end
    end

`ifdef PULSE_WIDTH_MEASURE_EN
    assign o_Busy  = (state_q == S_COUNT) || (state_q == S_WIDTH);
    assign o_Width = width_q;
`else
    assign o_Busy  = (state_q == S_COUNT);
`endif
    assign o_Valid   = valid_q;
    assign o_Timeout = timeout_q;
    assign o_Delay   = delay_q;

endmodule

// File: doc/propagation_time_meter.md
PROPAGATION_TIME_METER -- requirements
Module: propagation_time_meter

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 38, width of delay/width counters (2^38 ticks max, no overflow beyond TIMEOUT_TICKS).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 1000000, maximum ticks waited for echo edge; must be < 2^COUNTER_WIDTH.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, minimum 2, flop count of the i_Echo synchronizer.
REQ-004 i_Clk  input  1  system clock, all logic on rising edge.
REQ-005 i_Rst  input  1  synchronous, active-high reset.
REQ-006 i_Enable  input  1  high = meter active; low = force IDLE, clear state.
REQ-007 i_Start  input  1  launched pulse, synchronous to i_Clk (from the pulse emitter); rising edge starts a measurement.
REQ-008 i_Echo  input  1  returned pulse, asynchronous; rising edge ends a measurement.
REQ-009 i_Ack  input  1  consumer acknowledge of o_Valid.
REQ-010 o_Busy  output  1  high in ARMED-after-start (COUNT) and WIDTH states.
REQ-011 o_Valid  output  1  result available; held until acknowledged.
REQ-012 o_Timeout  output  1  qualifies o_Valid: no echo within TIMEOUT_TICKS.
REQ-013 o_Delay  output  COUNTER_WIDTH  measured start-to-echo ticks.

Function
REQ-014 FSM states SHALL be IDLE, ARMED, COUNT, WIDTH (macro only), DONE.
REQ-015 IDLE -> ARMED when i_Enable high; any state -> IDLE when i_Enable low, clearing counters, o_Valid, o_Timeout, o_Delay.
REQ-016 Start edge SHALL be i_Start high in current cycle and low in previous cycle; echo edge SHALL be synchronized echo high, previous synchronized value low.
REQ-017 ARMED + start edge -> COUNT, counter cleared to 0; echo edges in ARMED ignored.
REQ-018 COUNT: counter increments by 1 per cycle; echo edge N cycles after start-edge cycle SHALL yield o_Delay = N (synchronizer latency included, not compensated).
REQ-019 Loopback (i_Echo tied to i_Start) SHALL yield o_Delay = SYNC_STAGES.
REQ-020 COUNT: counter reaching TIMEOUT_TICKS without echo edge -> DONE, o_Timeout=1, o_Delay=TIMEOUT_TICKS.
REQ-021 Echo edge and timeout in same cycle: echo wins, o_Timeout=0.
REQ-022 Echo already high at start edge SHALL not terminate; a fresh rising edge is required.
REQ-023 o_Valid, o_Delay, o_Timeout registered; o_Valid asserted first cycle in DONE.
REQ-024 DONE: outputs held stable; start and echo edges ignored; i_Ack high -> ARMED, o_Valid low next cycle.
REQ-025 Start edge coincident with i_Ack SHALL be ignored (not a new measurement).
REQ-026 i_Ack outside DONE SHALL have no effect.

Reset
REQ-027 i_Rst SHALL force IDLE, counters 0, synchronizer and edge-detect history 0, o_Busy=0, o_Valid=0, o_Timeout=0, o_Delay=0 (o_Width=0 with macro), including mid-measurement.
REQ-028 i_Rst SHALL take priority over i_Enable and i_Ack.

Configuration
REQ-029 Macro PULSE_WIDTH_MEASURE_EN defined: output o_Width (COUNTER_WIDTH) added; echo edge in COUNT latches o_Delay -> WIDTH; WIDTH counts cycles synchronized echo stays high; falling edge -> DONE with o_Width = high-cycle count; width reaching TIMEOUT_TICKS -> DONE with o_Timeout=1, o_Width=TIMEOUT_TICKS.
REQ-030 Macro undefined: no o_Width port, no WIDTH state; echo edge in COUNT -> DONE directly.

Verification
REQ-031 Loopback i_Echo=i_Start, SYNC_STAGES=2, 5-cycle start pulse -> o_Valid=1, o_Delay=2, o_Timeout=0.
REQ-032 Echo rises 100 cycles after i_Start at input -> o_Delay=102; i_Ack 1 cycle -> o_Valid low next cycle, ARMED.
REQ-033 TIMEOUT_TICKS=50, echo never rises -> o_Valid=1, o_Timeout=1, o_Delay=50 exactly 50 cycles after start edge.
REQ-034 Second start edge during DONE and echo pulses during DONE -> o_Delay unchanged, no new measurement until i_Ack.
REQ-035 i_Rst pulsed at cycle 30 of COUNT -> all outputs 0 next cycle; i_Enable low mid-COUNT -> IDLE, outputs cleared.
REQ-036 Macro defined, echo high 40 synchronized cycles, delay 10 -> o_Delay=12, o_Width=40, o_Valid after echo fall.
